// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: round-robin arbiter for two command requesters plus an
// SS_n-framed SPI sequencer that shifts a 10-bit command word out on MOSI
// and, for read-data commands, captures one byte from MISO.
module spi_master_ctrl #(
   parameter int unsigned RD_LAT = 3,
   parameter int unsigned GAP    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req0,
   input  logic                    req1,
   input  logic [9:0]              word0,
   input  logic [9:0]              word1,
   output logic                    gnt0,
   output logic                    gnt1,
   output logic                    done,
   output logic                    done_id,
   output logic [7:0]              rdata,
   output logic                    busy,
   output logic                    SS_n,
   output logic                    MOSI,
   input  logic                    MISO
);

   localparam int unsigned WORD_W = 10;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_START, S_CMD, S_SHIFT,
      S_HOLD, S_RD_WAIT, S_RD_CAP, S_END, S_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic [DATA_W-1:0]   cap_q, cap_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rd_q, rd_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                gnt0_q, gnt0_d;
   logic                gnt1_q, gnt1_d;
   logic                done_q, done_d;
   logic                done_id_q, done_id_d;
   logic                busy_q, busy_d;
   logic                ss_n_q, ss_n_d;
   logic                mosi_q, mosi_d;
   logic                win;
   logic [WORD_W-1:0]   word_sel;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      cap_d     = cap_q;
      rdata_d   = rdata_q;
      rd_d      = rd_q;
      owner_d   = owner_q;
      last_d    = last_q;
      done_id_d = done_id_q;
      win       = (req0 && req1) ? ~last_q : req1;
      word_sel  = owner_q ? word1 : word0;

      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_ARB;
               owner_d = win;
            end
         end
         S_ARB: begin
            state_d = S_START;
            shreg_d = word_sel;
            rd_d    = (word_sel[9:8] == 2'b11);
         end
         S_START: state_d = S_CMD;
         S_CMD: begin
            state_d = S_SHIFT;
            cnt_d   = CNT_W'(WORD_W - 1);
         end
         S_SHIFT: begin
            if (cnt_q == '0) begin
               if (rd_q) begin
                  state_d = S_RD_WAIT;
                  cnt_d   = CNT_W'(RD_LAT - 1);
               end else begin
                  state_d = S_HOLD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HOLD: state_d = S_END;
         S_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RD_CAP;
               cnt_d   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RD_CAP: begin
            cap_d = {cap_q[DATA_W-2:0], MISO};
            if (cnt_q == '0) begin
               state_d = S_END;
               rdata_d = cap_d;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_END: begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(GAP - 1);
            last_d  = owner_q;
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               if (req0 || req1) begin
                  state_d = S_ARB;
                  owner_d = win;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it
      mosi_d = 1'b0;
      if (state_d == S_CMD) begin
         mosi_d = shreg_q[WORD_W-1];
      end else if (state_d == S_SHIFT) begin
         mosi_d  = shreg_q[WORD_W-1];
         shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
      end
      gnt0_d = (state_d == S_ARB) && !owner_d;
      gnt1_d = (state_d == S_ARB) &&  owner_d;
      done_d = (state_d == S_END);
      if (state_d == S_END) begin
         done_id_d = owner_q;
      end
      busy_d = (state_d != S_IDLE);
      ss_n_d = !(state_d inside {S_START, S_CMD, S_SHIFT, S_HOLD, S_RD_WAIT, S_RD_CAP});
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         cap_q     <= '0;
         rdata_q   <= '0;
         rd_q      <= 1'b0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         busy_q    <= 1'b0;
         ss_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         cap_q     <= cap_d;
         rdata_q   <= rdata_d;
         rd_q      <= rd_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         busy_q    <= busy_d;
         ss_n_q    <= ss_n_d;
         mosi_q    <= mosi_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign rdata   = rdata_q;
   assign busy    = busy_q;
   assign SS_n    = ss_n_q;
   assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus queues expected grants and
// frame completions, a negedge monitor pops and compares them.
module tb_spi_master_ctrl;

   localparam int unsigned RD_LAT = 3;
   localparam int unsigned GAP    = 1;

   typedef struct packed {
      logic       id;
      logic [7:0] rd;
   } dexp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [9:0] word0, word1;
   logic       gnt0, gnt1, done, done_id, busy, SS_n, MOSI, MISO;
   logic [7:0] rdata;

   int    n_checks = 0;
   int    n_errors = 0;
   bit    exp_g[$];
   dexp_t exp_d[$];
   logic [7:0] exp_rd;

   spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .word0(word0), .word1(word1), .gnt0(gnt0), .gnt1(gnt1),
      .done(done), .done_id(done_id), .rdata(rdata), .busy(busy),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // Monitor: every grant and every done is matched against the scoreboard
   always @(negedge clk) begin
      if (gnt0 || gnt1) begin
         check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
         if (exp_g.size() == 0) begin
            fail($sformatf("unexpected_gnt id=%0d", gnt1));
         end else begin
            check("gnt_id", 32'(gnt1), 32'(exp_g.pop_front()));
         end
      end
      if (done) begin
         dexp_t e;
         check("done_gnt_apart", 32'(gnt0 | gnt1), 32'd0);
         if (exp_d.size() == 0) begin
            fail($sformatf("unexpected_done id=%0d", done_id));
         end else begin
            e = exp_d.pop_front();
            check("done_id", 32'(done_id), 32'(e.id));
            check("rdata", 32'(rdata), 32'(e.rd));
         end
      end
   end

   // Waits (bounded) for the given grant; n = negedges waited
   task automatic wait_gnt(input bit id, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((id ? gnt1 : gnt0) !== 1'b1) && n < 100);
      if ((id ? gnt1 : gnt0) !== 1'b1) fail($sformatf("gnt%0d_timeout", id));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_d.size() != 0 || exp_g.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
   endtask

   // One frame from an idle controller, checking the serial waveform
   task automatic do_frame(input bit id, input logic [9:0] w, input logic [7:0] mb, input bit chk_lat);
      int  n;
      bit  rd;
      dexp_t e;
      rd = (w[9:8] == 2'b11);
      e.id = id;
      e.rd = rd ? mb : exp_rd;
      exp_g.push_back(id);
      exp_d.push_back(e);
      exp_rd = e.rd;
      if (id) begin word1 = w; req1 = 1'b1; end
      else    begin word0 = w; req0 = 1'b1; end
      wait_gnt(id, n);
      if (chk_lat) check("gnt_latency", 32'(n), 32'd1);
      if (id) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      check("ss_low_start", 32'(SS_n), 32'd0);
      @(negedge clk);
      check("cmd_bit", 32'(MOSI), 32'(w[9]));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("mosi_bit%0d", 9 - i), 32'(MOSI), 32'(w[9 - i]));
      end
      if (rd) begin
         repeat (RD_LAT) @(negedge clk);
         check("rdwait_ss", 32'(SS_n), 32'd0);
         check("rdwait_mosi", 32'(MOSI), 32'd0);
         for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            MISO = mb[7 - j];
         end
         @(negedge clk);
         MISO = 1'b0;
         check("rd_done", 32'(done), 32'd1);
      end else begin
         @(negedge clk);
         check("hold_ss", 32'(SS_n), 32'd0);
         @(negedge clk);
         check("wr_done", 32'(done), 32'd1);
      end
      check("end_ss_high", 32'(SS_n), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   // Stimulus
   initial begin
      int n;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      word0 = '0; word1 = '0; MISO = 1'b0; exp_rd = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ss_n", 32'(SS_n), 32'd1);
      check("rst_mosi", 32'(MOSI), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_done", 32'({done, done_id, gnt0, gnt1}), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Write address from requester 0, then read data from requester 1
      do_frame(1'b0, 10'h03C, 8'h00, 1'b1);
      do_frame(1'b1, 10'h300, 8'hA5, 1'b1);

      // Contention: both high together
      word0 = 10'h012; word1 = 10'h134;
      exp_g.push_back(1'b0); exp_g.push_back(1'b1); exp_g.push_back(1'b0);
      exp_d.push_back('{1'b0, exp_rd}); exp_d.push_back('{1'b1, exp_rd});
      exp_d.push_back('{1'b0, exp_rd});
      req0 = 1'b1; req1 = 1'b1;
      wait_gnt(1'b0, n);
      wait_gnt(1'b1, n);
      req1 = 1'b0;
      wait_gnt(1'b0, n);
      req0 = 1'b0;
      wait_idle();

      // Back-to-back: req0 held for three frames
      word0 = 10'h0AA;
      for (int f = 0; f < 3; f++) begin
         exp_g.push_back(1'b0);
         exp_d.push_back('{1'b0, exp_rd});
      end
      req0 = 1'b1;
      for (int f = 0; f < 3; f++) begin
         wait_gnt(1'b0, n);
         if (f > 0) check("b2b_gnt_spacing", 32'(n), 32'd16);
         else       check("b2b_first_latency", 32'(n), 32'd1);
         if (f == 2) req0 = 1'b0;
      end
      wait_idle();

      // Withdrawn request: req1 pulsed once during a busy frame
      fork
         do_frame(1'b0, 10'h181, 8'h00, 1'b1);
         begin
            repeat (6) @(negedge clk);
            word1 = 10'h011;
            req1  = 1'b1;
            @(negedge clk);
            req1  = 1'b0;
         end
      join
      repeat (25) @(negedge clk);

      // Reset in SHIFT bit 5 of a requester-1 frame
      word1 = 10'h155;
      exp_g.push_back(1'b1);
      req1 = 1'b1;
      wait_gnt(1'b1, n);
      req1 = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ss_n", 32'(SS_n), 32'd1);
      check("midrst_mosi", 32'(MOSI), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_rdata", 32'(rdata), 32'd0);
      rst = 1'b0;
      exp_rd = 8'h00;
      repeat (5) @(negedge clk);
      check("midrst_idle_ss", 32'(SS_n), 32'd1);

      // Pointer back to requester 0 after reset
      word0 = 10'h0F0; word1 = 10'h10F;
      exp_g.push_back(1'b0); exp_g.push_back(1'b1);
      exp_d.push_back('{1'b0, 8'h00}); exp_d.push_back('{1'b1, 8'h00});
      req0 = 1'b1; req1 = 1'b1;
      wait_gnt(1'b0, n);
      check("post_rst_latency", 32'(n), 32'd1);
      req0 = 1'b0;
      wait_gnt(1'b1, n);
      req1 = 1'b0;
      wait_idle();

      check("gnt_queue_empty", 32'(exp_g.size()), 32'd0);
      check("done_queue_empty", 32'(exp_d.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

endmodule
